// File: rtl/serial_word_collector.sv
// Receive end of a bit-select serial line: collects WIDTH addressed bits into a
// word, presents it with a valid/ack handshake and flags duplicate/overrun errors.
module serial_word_collector #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SEL_W  = 4,
  parameter bit          INVERT = 1'b1
) (
  input  logic             clk_pad,
  input  logic             rst_pad,
  input  logic             ser_pad,
  input  logic             en_n_pad,
  input  logic [SEL_W-1:0] sel_pad,
  input  logic             ack_pad,
  input  logic             err_clr_pad,
  output logic [WIDTH-1:0] word_pad,
  output logic             valid_pad,
  output logic [SEL_W:0]   cnt_pad,
  output logic             dup_err_pad,
  output logic             ovr_pad
);

  typedef enum logic {COLLECT, FULL} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic [WIDTH-1:0]   mask_q, mask_d;
  logic [SEL_W:0]     cnt_q, cnt_d;
  logic               dup_q, dup_d;
  logic               ovr_q, ovr_d;

  logic               sample;
  logic               bit_val;
  logic               rel;
  logic [WIDTH-1:0]   mask_base;
  logic [SEL_W:0]     cnt_base;

  always_ff @(posedge clk_pad) begin
    if (rst_pad) state_q <= COLLECT;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (!en_n_pad && !mask_q[sel_pad] &&
                   cnt_q == (SEL_W+1)'(WIDTH - 1)) state_d = FULL;
      FULL:    if (ack_pad) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  // A release (FULL with ack) restarts from an empty mask, so a sample on the
  // same edge becomes the first bit of the next word instead of an overrun.
  always_comb begin
    sample    = !en_n_pad;
    bit_val   = ser_pad ^ INVERT;
    rel       = (state_q == FULL) && ack_pad;
    mask_base = rel ? '0 : mask_q;
    cnt_base  = rel ? '0 : cnt_q;
    word_d    = word_q;
    mask_d    = mask_base;
    cnt_d     = cnt_base;
    dup_d     = dup_q;
    ovr_d     = ovr_q;
    if (sample && (state_q == COLLECT || ack_pad)) begin
      word_d[sel_pad] = bit_val;
      mask_d[sel_pad] = 1'b1;
      if (mask_base[sel_pad]) dup_d = 1'b1;
      else                    cnt_d = cnt_base + (SEL_W+1)'(1);
    end
    if (sample && state_q == FULL && !ack_pad) ovr_d = 1'b1;
    if (err_clr_pad) begin
      dup_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk_pad) begin
    if (rst_pad) begin
      word_q <= '0;
      mask_q <= '0;
      cnt_q  <= '0;
      dup_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
      dup_q  <= dup_d;
      ovr_q  <= ovr_d;
    end
  end

  always_comb begin
    valid_pad   = (state_q == FULL);
    word_pad    = word_q;
    cnt_pad     = cnt_q;
    dup_err_pad = dup_q;
    ovr_pad     = ovr_q;
  end

endmodule

// File: tb/tb_serial_word_collector.sv
// Randomised and directed bench for serial_word_collector against a set/mask
// reference model, plus literal expectations for the directed scenarios.
module tb_serial_word_collector;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ser = 1'b0;
  logic        en_n = 1'b1;
  logic [3:0]  sel = '0;
  logic        ack = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] word;
  logic        valid;
  logic [4:0]  cnt;
  logic        dup;
  logic        ovr;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // reference model state
  logic [15:0] m_word = '0;
  logic [15:0] m_mask = '0;
  bit          m_full = 1'b0;
  bit          m_dup = 1'b0;
  bit          m_ovr = 1'b0;

  serial_word_collector #(.WIDTH(16), .SEL_W(4), .INVERT(1'b1)) dut (
    .clk_pad(clk), .rst_pad(rst), .ser_pad(ser), .en_n_pad(en_n),
    .sel_pad(sel), .ack_pad(ack), .err_clr_pad(clr),
    .word_pad(word), .valid_pad(valid), .cnt_pad(cnt),
    .dup_err_pad(dup), .ovr_pad(ovr)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: word position set, mask of seen positions, full when every position seen.
  always @(posedge clk) begin
    if (rst) begin
      m_word = '0; m_mask = '0; m_full = 0; m_dup = 0; m_ovr = 0;
    end else begin
      if (!m_full) begin
        if (!en_n) begin
          if (m_mask[sel]) m_dup = 1;
          m_word[sel] = ~ser;
          m_mask[sel] = 1'b1;
          if (m_mask == 16'hFFFF) m_full = 1;
        end
      end else if (ack) begin
        m_full = 0;
        m_mask = '0;
        if (!en_n) begin
          m_word[sel] = ~ser;
          m_mask[sel] = 1'b1;
        end
      end else if (!en_n) begin
        m_ovr = 1;
      end
      if (clr) begin
        m_dup = 0; m_ovr = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("m_word",  32'(word),  32'(m_word));
      cmp("m_valid", 32'(valid), 32'(m_full));
      cmp("m_cnt",   32'(cnt),   32'($countones(m_mask)));
      cmp("m_dup",   32'(dup),   32'(m_dup));
      cmp("m_ovr",   32'(ovr),   32'(m_ovr));
    end
  end

  task automatic step(input bit i_en_n, input logic [3:0] i_sel, input bit i_ser,
                      input bit i_ack, input bit i_clr, input bit i_rst);
    en_n = i_en_n; sel = i_sel; ser = i_ser; ack = i_ack; clr = i_clr; rst = i_rst;
    @(posedge clk);
    #1;
    en_n = 1'b1; ack = 1'b0; clr = 1'b0; rst = 1'b0;
  endtask

  task automatic idle();
    step(1, 4'd0, 0, 0, 0, 0);
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int unsigned i = 0; i < 16; i++) begin
      logic [15:0] t;
      t = w;
      step(0, 4'(i), ~t[i], 0, 0, 0);
    end
  endtask

  initial begin
    logic [15:0] pat;
    logic [3:0]  order [16];
    step(1, 4'd0, 0, 0, 0, 1);
    step(1, 4'd0, 0, 0, 0, 1);
    chk_en = 1'b1;
    cmp("reset_word", 32'(word), 0);
    cmp("reset_cnt", 32'(cnt), 0);
    cmp("reset_valid", 32'(valid), 0);

    // 1: in-order word 0xA5C3
    pat = 16'hA5C3;
    for (int unsigned i = 0; i < 15; i++) step(0, 4'(i), ~pat[i], 0, 0, 0);
    cmp("t1_valid_at_15", 32'(valid), 0);
    cmp("t1_cnt_at_15", 32'(cnt), 15);
    step(0, 4'd15, ~pat[15], 0, 0, 0);
    cmp("t1_valid", 32'(valid), 1);
    cmp("t1_word", 32'(word), 32'h0000A5C3);
    cmp("t1_cnt", 32'(cnt), 16);
    step(1, 4'd0, 0, 1, 0, 0);
    cmp("t1_rel_valid", 32'(valid), 0);
    cmp("t1_rel_cnt", 32'(cnt), 0);
    cmp("t1_rel_word", 32'(word), 32'h0000A5C3);

    // 2: out-of-order with idle gaps
    for (int i = 0; i < 16; i++) order[i] = 4'(i);
    for (int i = 15; i > 0; i--) begin
      int j; logic [3:0] t;
      j = int'($urandom_range(i, 0));
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < 16; i++)
      if (order[i] == 4'd15) begin order[i] = order[0]; order[0] = 4'd15; end
    pat = 16'($urandom);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) cmp("t2_valid_before_last", 32'(valid), 0);
      step(0, order[i], ~pat[order[i]], 0, 0, 0);
      repeat ($urandom_range(2, 0)) idle();
    end
    cmp("t2_word", 32'(word), 32'(pat));
    cmp("t2_valid", 32'(valid), 1);
    step(1, 4'd0, 0, 1, 0, 0);

    // 3: duplicate on sel 5, stored 1 then 0
    step(0, 4'd5, 0, 0, 0, 0);
    step(0, 4'd5, 1, 0, 0, 0);
    cmp("t3_bit5", 32'(word[5]), 0);
    cmp("t3_dup", 32'(dup), 1);
    cmp("t3_cnt", 32'(cnt), 1);
    step(1, 4'd0, 0, 0, 1, 0);
    cmp("t3_dup_clr", 32'(dup), 0);

    // 4: overrun while FULL with 0x1234
    send_word(16'h1234);
    cmp("t4_valid", 32'(valid), 1);
    step(0, 4'd2, 1, 0, 0, 0);
    step(0, 4'd7, 0, 0, 0, 0);
    cmp("t4_ovr", 32'(ovr), 1);
    cmp("t4_word", 32'(word), 32'h00001234);
    step(1, 4'd0, 0, 0, 1, 0);
    cmp("t4_ovr_clr", 32'(ovr), 0);

    // 5: release with simultaneous sample sel=9 ser=0
    step(0, 4'd9, 0, 1, 0, 0);
    cmp("t5_valid", 32'(valid), 0);
    cmp("t5_cnt", 32'(cnt), 1);
    cmp("t5_bit9", 32'(word[9]), 1);
    cmp("t5_ovr", 32'(ovr), 0);

    // 6: reset mid-word, then full reception
    step(1, 4'd0, 0, 0, 0, 1);
    for (int unsigned i = 0; i < 8; i++) step(0, 4'(i), 0, 0, 0, 0);
    step(1, 4'd0, 0, 0, 0, 1);
    cmp("t6_word", 32'(word), 0);
    cmp("t6_cnt", 32'(cnt), 0);
    send_word(16'hBEEF);
    cmp("t6_full_word", 32'(word), 32'h0000BEEF);
    cmp("t6_full_valid", 32'(valid), 1);
    step(1, 4'd0, 0, 1, 0, 0);

    // random traffic checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(99, 0) < 40, 4'($urandom), 1'($urandom),
           $urandom_range(99, 0) < 20, $urandom_range(99, 0) < 5,
           $urandom_range(999, 0) < 5);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
